pipe_ctrl: RTL and testbench

- Pipeline sequencer for the IF/ID/EX/MEM/WB core.
- Drives every stage enable.
- Inserts load-use bubbles and flushes wrong-path instructions on a taken branch/jump resolved in `execute`.
- Freezes the whole pipe on a memory stall, and generates EX operand forwarding selects from its own shadow copy of in-flight destination registers.

---
 rtl/pipe_ctrl_pkg.sv | 25 ++
 rtl/pipe_ctrl_fwd_sel.sv | 18 +
 rtl/pipe_ctrl.sv | 104 ++++++++++
 tb/tb_pipe_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state/forwarding encodings and shadow-register layouts
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {PC_RUN = 2'd0, PC_FLUSH = 2'd1, PC_FREEZE = 2'd2} pc_state_t;
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB = 2'd2;
  typedef struct packed {
    logic v;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic use1;
    logic use2;
    logic ld;
  } ex_sh_t;
  typedef struct packed {
    logic v;
    logic [4:0] rd;
    logic ld;
  } mem_sh_t;
  typedef struct packed {
    logic v;
    logic [4:0] rd;
  } wb_sh_t;
endpackage

// File: rtl/pipe_ctrl_fwd_sel.sv
// fwd_sel: EX operand forwarding select for one source register
module fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_v,
  input  logic       use_rs,
  input  logic [4:0] rs,
  input  logic       mem_v,
  input  logic       mem_ld,
  input  logic [4:0] mem_rd,
  input  logic       wb_v,
  input  logic [4:0] wb_rd,
  output logic [1:0] fwd
);
  // A load in MEM has no data yet, so it never forwards from MEM
  always_comb fwd = (ex_v && use_rs && mem_v && !mem_ld && mem_rd != '0 && mem_rd == rs) ? FWD_MEM :
                    (wb_v && wb_rd != '0 && wb_rd == rs) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for stage enables, load-use bubbles, redirect flushes and forwarding
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYC = 2,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [4:0]      id_rd,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            id_load,
  input  logic            ex_taken,
  input  logic            mem_busy,
  output logic            en_if,
  output logic            en_id,
  output logic            en_ex,
  output logic            en_mem,
  output logic            en_wb,
  output logic            flush_id,
  output logic            bubble_ex,
  output logic [1:0]      fwd1,
  output logic [1:0]      fwd2,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);
  pc_state_t state, nxt_state;
  logic [31:0] fcnt, nxt_fcnt;
  ex_sh_t ex_q;
  mem_sh_t mem_q;
  wb_sh_t wb_q;
  logic id_v, taken, hazard, stall;
  logic [4:0] en;
  logic [1:0] f1, f2;
  assign id_v = id_valid && state != PC_FLUSH;
  assign taken = ex_taken && ex_q.v;
  assign hazard = id_v && ex_q.v && ex_q.ld && ex_q.rd != '0 &&
                  ((id_use_rs1 && id_rs1 == ex_q.rd) || (id_use_rs2 && id_rs2 == ex_q.rd));
  // mem_busy acts as the FREEZE override: nothing moves and the pending decision is replayed later
  always_comb begin
    en = '0;
    flush_id = 1'b0;
    bubble_ex = 1'b0;
    stall = 1'b0;
    nxt_state = state;
    nxt_fcnt = fcnt;
    if (rst || mem_busy) begin
      stall = mem_busy && !rst;
    end else if (taken) begin
      en = '1;
      flush_id = 1'b1;
      bubble_ex = 1'b1;
      nxt_state = FLUSH_CYC > 1 ? PC_FLUSH : PC_RUN;
      nxt_fcnt = FLUSH_CYC > 1 ? 32'(FLUSH_CYC - 2) : '0;
    end else if (state == PC_FLUSH) begin
      en = '1;
      flush_id = 1'b1;
      nxt_state = fcnt == '0 ? PC_RUN : PC_FLUSH;
      nxt_fcnt = fcnt == '0 ? '0 : fcnt - 32'd1;
    end else if (hazard) begin
      en = 5'b00111;
      bubble_ex = 1'b1;
      stall = 1'b1;
    end else begin
      en = '1;
    end
  end
  assign {en_if, en_id, en_ex, en_mem, en_wb} = en;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PC_RUN;
      fcnt <= '0;
      ex_q.v <= 1'b0;
      mem_q.v <= 1'b0;
      wb_q.v <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!mem_busy) begin
        state <= nxt_state;
        fcnt <= nxt_fcnt;
        wb_q <= {mem_q.v, mem_q.rd};
        mem_q <= {ex_q.v, ex_q.rd, ex_q.ld};
        ex_q <= bubble_ex ? '0 : {id_v, id_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_load};
      end
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNTW'(1);
      if (taken && !mem_busy && !(&flush_cnt)) flush_cnt <= flush_cnt + CNTW'(1);
    end
  end
  fwd_sel u_fwd1 (
    .ex_v(ex_q.v), .use_rs(ex_q.use1), .rs(ex_q.rs1), .mem_v(mem_q.v), .mem_ld(mem_q.ld),
    .mem_rd(mem_q.rd), .wb_v(wb_q.v), .wb_rd(wb_q.rd), .fwd(f1)
  );
  fwd_sel u_fwd2 (
    .ex_v(ex_q.v), .use_rs(ex_q.use2), .rs(ex_q.rs2), .mem_v(mem_q.v), .mem_ld(mem_q.ld),
    .mem_rd(mem_q.rd), .wb_v(wb_q.v), .wb_rd(wb_q.rd), .fwd(f2)
  );
  assign fwd1 = rst ? FWD_RF : f1;
  assign fwd2 = rst ? FWD_RF : f2;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed test-plan steps then random traffic against an in-flight instruction model
module tb_pipe_ctrl;
  localparam int FLUSH_CYC = 2;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;
  logic clk = 1'b0;
  logic rst, id_valid, id_use_rs1, id_use_rs2, id_load, ex_taken, mem_busy;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic en_if, en_id, en_ex, en_mem, en_wb, flush_id, bubble_ex;
  logic [1:0] fwd1, fwd2;
  logic [CNTW-1:0] stall_cnt, flush_cnt;
  int n_checks = 0;
  int n_errors = 0;
  typedef struct packed {
    logic v;
    logic [4:0] rd, rs1, rs2;
    logic u1, u2, ld;
  } ins_t;
  ins_t st [3];
  int flush_left = 0;
  int m_stalls = 0;
  int m_flushes = 0;
  always #5 clk = ~clk;
  pipe_ctrl #(.FLUSH_CYC(FLUSH_CYC), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_load(id_load), .ex_taken(ex_taken),
    .mem_busy(mem_busy), .en_if(en_if), .en_id(en_id), .en_ex(en_ex), .en_mem(en_mem), .en_wb(en_wb),
    .flush_id(flush_id), .bubble_ex(bubble_ex), .fwd1(fwd1), .fwd2(fwd2),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int sat(int c);
    return c > CMAX ? CMAX : c;
  endfunction
  function automatic logic m_taken();
    return ex_taken && st[0].v;
  endfunction
  function automatic logic m_hazard();
    return id_valid && flush_left == 0 && st[0].v && st[0].ld && st[0].rd != 0 &&
           ((id_use_rs1 && id_rs1 == st[0].rd) || (id_use_rs2 && id_rs2 == st[0].rd));
  endfunction
  function automatic logic [1:0] m_fwd(logic [4:0] rs, logic u);
    if (st[0].v && u && st[1].v && !st[1].ld && st[1].rd != 0 && st[1].rd == rs) return 2'd1;
    if (st[2].v && st[2].rd != 0 && st[2].rd == rs) return 2'd2;
    return 2'd0;
  endfunction
  task automatic set_id(logic v, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2, logic ld);
    id_valid = v; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = u1; id_use_rs2 = u2; id_load = ld;
  endtask
  task automatic eval();
    logic [4:0] e_en;
    logic e_fl, e_bub;
    logic [1:0] e1, e2;
    #2;
    e_en = 5'h1f; e_fl = 1'b0; e_bub = 1'b0;
    e1 = m_fwd(st[0].rs1, st[0].u1);
    e2 = m_fwd(st[0].rs2, st[0].u2);
    if (rst) begin
      e_en = '0; e1 = '0; e2 = '0;
    end else if (mem_busy) e_en = '0;
    else if (m_taken()) begin
      e_fl = 1'b1; e_bub = 1'b1;
    end else if (flush_left > 0) e_fl = 1'b1;
    else if (m_hazard()) begin
      e_en = 5'b00111; e_bub = 1'b1;
    end
    chk("en", {27'd0, en_if, en_id, en_ex, en_mem, en_wb}, {27'd0, e_en});
    chk("flush_id", {31'd0, flush_id}, {31'd0, e_fl});
    chk("bubble_ex", {31'd0, bubble_ex}, {31'd0, e_bub});
    chk("fwd1", {30'd0, fwd1}, {30'd0, e1});
    chk("fwd2", {30'd0, fwd2}, {30'd0, e2});
  endtask
  task automatic model_update();
    logic tk, hz;
    tk = m_taken();
    hz = m_hazard();
    if (rst) begin
      for (int i = 0; i < 3; i++) st[i] = '0;
      flush_left = 0; m_stalls = 0; m_flushes = 0;
    end else if (mem_busy) m_stalls++;
    else begin
      if (tk) m_flushes++;
      else if (hz) m_stalls++;
      st[2] = st[1];
      st[1] = st[0];
      st[0] = (tk || hz) ? '0 :
              {id_valid && flush_left == 0, id_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_load};
      flush_left = tk ? FLUSH_CYC - 1 : (flush_left > 0 ? flush_left - 1 : 0);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    chk("stall_cnt", {28'd0, stall_cnt}, 32'(sat(m_stalls)));
    chk("flush_cnt", {28'd0, flush_cnt}, 32'(sat(m_flushes)));
  endtask
  initial begin
    for (int i = 0; i < 3; i++) st[i] = '0;
    rst = 1'b1; ex_taken = 1'b0; mem_busy = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    eval(); tick();
    eval(); tick();
    rst = 1'b0;
    eval();
    chk("tp1_en", {27'd0, en_if, en_id, en_ex, en_mem, en_wb}, 32'h1f);
    chk("tp1_fwd", {28'd0, fwd1, fwd2}, 32'd0);
    chk("tp1_cnt", {24'd0, stall_cnt, flush_cnt}, 32'd0);
    tick();
    set_id(1, 5, 1, 2, 0, 0, 1);
    eval(); tick();
    set_id(1, 6, 5, 7, 1, 1, 0);
    eval();
    chk("tp2_en_if", {31'd0, en_if}, 32'd0);
    chk("tp2_bubble", {31'd0, bubble_ex}, 32'd1);
    tick();
    chk("tp2_stall_cnt", {28'd0, stall_cnt}, 32'd1);
    eval();
    chk("tp2_no_restall", {31'd0, en_id}, 32'd1);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    eval();
    chk("tp2_fwd_wb", {30'd0, fwd1}, 32'd2);
    tick();
    set_id(1, 3, 1, 2, 1, 1, 0);
    eval(); tick();
    set_id(1, 4, 3, 3, 1, 1, 0);
    eval(); tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    eval();
    chk("tp3_fwd_mem", {28'd0, fwd1, fwd2}, 32'h5);
    tick();
    set_id(1, 0, 1, 2, 1, 1, 0);
    eval(); tick();
    set_id(1, 7, 0, 0, 1, 1, 0);
    eval(); tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    eval();
    chk("tp3_fwd_x0", {28'd0, fwd1, fwd2}, 32'd0);
    tick();
    set_id(1, 8, 1, 2, 0, 0, 0);
    eval(); tick();
    ex_taken = 1'b1;
    eval();
    chk("tp4_flush_first", {30'd0, flush_id, bubble_ex}, 32'h3);
    tick();
    chk("tp4_flush_cnt", {28'd0, flush_cnt}, 32'd1);
    ex_taken = 1'b0;
    eval();
    chk("tp4_flush_second", {30'd0, flush_id, bubble_ex}, 32'h2);
    tick();
    ex_taken = 1'b1;
    eval();
    chk("tp4_ignored_taken", {31'd0, flush_id}, 32'd0);
    tick();
    ex_taken = 1'b0;
    rst = 1'b1;
    eval(); tick();
    rst = 1'b0;
    set_id(1, 9, 1, 2, 0, 0, 0);
    eval(); tick();
    set_id(0, 0, 0, 0, 0, 0, 0);
    ex_taken = 1'b1; mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      eval();
      chk("tp5_frozen_en", {27'd0, en_if, en_id, en_ex, en_mem, en_wb}, 32'd0);
      tick();
    end
    chk("tp5_stall_cnt", {28'd0, stall_cnt}, 32'd3);
    mem_busy = 1'b0;
    eval();
    chk("tp5_flush_after", {31'd0, flush_id}, 32'd1);
    tick();
    chk("tp5_flush_cnt", {28'd0, flush_cnt}, 32'd1);
    ex_taken = 1'b0;
    rst = 1'b1;
    eval();
    chk("tp6_rst_flush", {31'd0, flush_id}, 32'd0);
    tick();
    rst = 1'b0; ex_taken = 1'b1;
    eval();
    chk("tp6_after_rst", {26'd0, flush_id, en_if, en_id, en_ex, en_mem, en_wb}, 32'h1f);
    tick();
    for (int i = 0; i < 600; i++) begin
      rst = $urandom_range(0, 39) == 0;
      mem_busy = $urandom_range(0, 4) == 0;
      ex_taken = $urandom_range(0, 3) == 0;
      set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0);
      eval(); tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
